// File: rtl/comp_64bit.sv
// Registered magnitude comparator: one-hot LT/EQ/GT code, zero-extended to WIDTH.
// 4-bit slices feed a log-depth priority tree; there is no wide subtractor.
module comp_64bit #(
   parameter int unsigned WIDTH  = 64,
   parameter bit          SIGNED = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] outp
);

   localparam int unsigned NSLICE = WIDTH / 4;
   localparam int unsigned LEVELS = (NSLICE > 1) ? $clog2(NSLICE) : 0;
   localparam int unsigned NPAD   = 1 << LEVELS;

   logic [NPAD-1:0]  slice_gt;
   logic [NPAD-1:0]  slice_eq;
   logic             gt_root;
   logic             eq_root;
   logic             lt_root;
   logic [WIDTH-1:0] outp_d;
   logic [WIDTH-1:0] outp_q;

   // Per-slice compare. Padding slices above the operand read as equal so they
   // always defer to the real slices below them.
   always_comb begin : slice_cmp
      logic [3:0] a_s;
      logic [3:0] b_s;
      slice_gt = '0;
      slice_eq = '1;
      a_s      = '0;
      b_s      = '0;
      for (int s = 0; s < int'(NSLICE); s++) begin
         a_s = A[4*s +: 4];
         b_s = B[4*s +: 4];
         // Flipping both sign bits turns two's-complement order into unsigned order.
         if (SIGNED && (s == int'(NSLICE) - 1)) begin
            a_s[3] = ~a_s[3];
            b_s[3] = ~b_s[3];
         end
         slice_gt[s] = (a_s > b_s);
         slice_eq[s] = (a_s == b_s);
      end
   end

   // Pairwise tree: the higher-order node wins unless it is equal.
   always_comb begin : cmp_tree
      logic [NPAD-1:0] gt_n [LEVELS+1];
      logic [NPAD-1:0] eq_n [LEVELS+1];
      for (int l = 0; l <= int'(LEVELS); l++) begin
         gt_n[l] = '0;
         eq_n[l] = '0;
      end
      gt_n[0] = slice_gt;
      eq_n[0] = slice_eq;
      for (int l = 0; l < int'(LEVELS); l++) begin
         for (int i = 0; i < int'(NPAD / 2); i++) begin
            if (i < int'(NPAD >> (l + 1))) begin
               gt_n[l+1][i] = gt_n[l][2*i+1] | (eq_n[l][2*i+1] & gt_n[l][2*i]);
               eq_n[l+1][i] = eq_n[l][2*i+1] & eq_n[l][2*i];
            end
         end
      end
      gt_root = gt_n[LEVELS][0];
      eq_root = eq_n[LEVELS][0];
   end

   always_comb begin
      lt_root = ~gt_root & ~eq_root;
      outp_d  = {{(WIDTH-3){1'b0}}, gt_root, eq_root, lt_root};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         outp_q <= '0;
      end else begin
         outp_q <= outp_d;
      end
   end

   assign outp = outp_q;

endmodule

// File: tb/tb_comp_64bit.sv
// Directed and random checks of comp_64bit, unsigned and signed instances side by side.
module tb_comp_64bit;

   localparam logic [63:0] CODE_LT = 64'h1;
   localparam logic [63:0] CODE_EQ = 64'h2;
   localparam logic [63:0] CODE_GT = 64'h4;

   logic        clk;
   logic        rst_n;
   logic [63:0] a;
   logic [63:0] b;
   logic [63:0] outp_u;
   logic [63:0] outp_s;

   int n_checks;
   int n_fail;

   comp_64bit #(
      .WIDTH  (64),
      .SIGNED (1'b0)
   ) u_dut_u (
      .clk   (clk),
      .rst_n (rst_n),
      .A     (a),
      .B     (b),
      .outp  (outp_u)
   );

   comp_64bit #(
      .WIDTH  (64),
      .SIGNED (1'b1)
   ) u_dut_s (
      .clk   (clk),
      .rst_n (rst_n),
      .A     (a),
      .B     (b),
      .outp  (outp_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] ref_code(input logic [63:0] x, input logic [63:0] y,
                                            input bit sgn);
      logic lt;
      logic gt;
      if (sgn) begin
         lt = ($signed(x) < $signed(y));
         gt = ($signed(x) > $signed(y));
      end else begin
         lt = (x < y);
         gt = (x > y);
      end
      if (lt) return CODE_LT;
      if (gt) return CODE_GT;
      return CODE_EQ;
   endfunction

   // Drive away from the edge, sample just after the capturing edge.
   task automatic apply(input logic [63:0] x, input logic [63:0] y);
      @(negedge clk);
      a = x;
      b = y;
      @(posedge clk);
      #1;
   endtask

   task automatic vec(input string tag, input logic [63:0] x, input logic [63:0] y,
                      input logic [63:0] exp_u, input logic [63:0] exp_s);
      apply(x, y);
      check_eq({tag, "_u"}, outp_u, exp_u);
      check_eq({tag, "_s"}, outp_s, exp_s);
   endtask

   initial begin
      logic [63:0] rx;
      logic [63:0] ry;
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      a        = 64'hAAAA_BBBB_CCCC_DDDD;
      b        = 64'h0;

      // Reset held for two edges.
      repeat (2) @(posedge clk);
      #1;
      check_eq("reset_u", outp_u, 64'h0);
      check_eq("reset_s", outp_s, 64'h0);

      // First edge after release captures the current compare.
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_eq("release_u", outp_u, CODE_GT);
      check_eq("release_s", outp_s, CODE_LT);

      vec("gt_mixed",   64'hAAAA_BBBB_CCCC_DDDD, 64'h1111_2222_3333_4444, CODE_GT, CODE_LT);
      vec("lt_zero",    64'h0,                   64'h1111_2222_3333_4554, CODE_LT, CODE_LT);
      vec("lt_aaaa",    64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB, CODE_LT, CODE_LT);
      vec("eq_mid",     64'h1111_2222_3333_4444, 64'h1111_2222_3333_4444, CODE_EQ, CODE_EQ);
      vec("hold_eq",    64'h1111_2222_3333_4444, 64'h1111_2222_3333_4444, CODE_EQ, CODE_EQ);
      vec("gt_vs_zero", 64'h1111_2222_3333_4444, 64'h0,                   CODE_GT, CODE_GT);
      vec("lt_bit0",    64'h1111_2222_3333_4444, 64'h1111_2222_3333_4445, CODE_LT, CODE_LT);
      vec("gt_bit0",    64'h1111_2222_3333_4445, 64'h1111_2222_3333_4444, CODE_GT, CODE_GT);
      vec("eq_zero",    64'h0,                   64'h0,                   CODE_EQ, CODE_EQ);
      vec("ones_zero",  64'hFFFF_FFFF_FFFF_FFFF, 64'h0,                   CODE_GT, CODE_LT);
      vec("min_max",    64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, CODE_GT, CODE_LT);
      vec("max_min",    64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, CODE_LT, CODE_GT);
      vec("eq_ones",    64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, CODE_EQ, CODE_EQ);
      vec("neg_order",  64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, CODE_LT, CODE_LT);

      // Reset mid-stream wins over a live compare, then recovers immediately.
      @(negedge clk);
      rst_n = 1'b0;
      a     = 64'h5;
      b     = 64'h3;
      @(posedge clk);
      #1;
      check_eq("midrst_u", outp_u, 64'h0);
      check_eq("midrst_s", outp_s, 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_eq("midrel_u", outp_u, CODE_GT);
      check_eq("midrel_s", outp_s, CODE_GT);

      for (int i = 0; i < 10000; i++) begin
         rx = {$urandom, $urandom};
         ry = {$urandom, $urandom};
         if (i % 16 == 0) ry = rx;
         apply(rx, ry);
         check_eq("rand_u", outp_u, ref_code(rx, ry, 1'b0));
         check_eq("rand_s", outp_s, ref_code(rx, ry, 1'b1));
      end

      for (int i = 0; i < 2000; i++) begin
         rx = {$urandom, $urandom};
         ry = rx ^ (64'h1 << $urandom_range(63, 0));
         apply(rx, ry);
         check_eq("bit1_u", outp_u, ref_code(rx, ry, 1'b0));
         check_eq("bit1_s", outp_s, ref_code(rx, ry, 1'b1));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
